// File: rtl/int_seq_pkg.sv
// Shared encodings for the interrupt entry/exit sequencer: FSM states and
// the injected memory-op codes.
package int_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRAIN  = 3'd1,
    PUSH_H = 3'd2,
    PUSH_L = 3'd3,
    PUSH_F = 3'd4,
    VECTOR = 3'd5,
    ISR    = 3'd6
  } seq_state_e;

  localparam logic [1:0] INJ_NONE   = 2'b00;
  localparam logic [1:0] INJ_PUSH16 = 2'b01;

endpackage

// File: rtl/int_pending_latch.sv
// Rising-edge detector on the external interrupt level plus the single-entry
// pending flag; a new edge wins over a simultaneous clear.
module int_pending_latch
  import int_seq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic int_level,
  input  logic clear,
  output logic pending
);

  logic int_prev;
  logic rise;

  always_comb begin
    rise = int_level & ~int_prev;
  end

  // int_prev resets high so a level already asserted through reset is not an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      int_prev <= 1'b1;
      pending  <= 1'b0;
    end else begin
      int_prev <= int_level;
      if (rise) begin
        pending <= 1'b1;
      end else if (clear) begin
        pending <= 1'b0;
      end else begin
        pending <= pending;
      end
    end
  end

endmodule

// File: rtl/int_sequencer.sv
// Interrupt entry/exit sequencer: drains the pipeline, injects three stack
// pushes (PC high, PC low, flags), loads the vector and tracks the ISR.
module int_sequencer
  import int_seq_pkg::*;
#(
  parameter int          DRAIN_CYC = 4,
  parameter logic [31:0] VEC_ADDR  = 32'h0000_0002
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Int,
  input  logic        branch_busy,
  input  logic [31:0] fetch_pc,
  input  logic [2:0]  flags,
  input  logic        rti_retire,
  input  logic        sp_ready,
  output logic        stall_fetch,
  output logic        inj_valid,
  output logic [1:0]  inj_op,
  output logic [15:0] inj_data,
  output logic        pc_load,
  output logic [31:0] pc_target,
  output logic        in_isr,
  output logic        int_ack
);

  localparam int CNT_W = (DRAIN_CYC < 1) ? 1 : $clog2(DRAIN_CYC + 1);

  seq_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      ret_pc_lo;
  logic [2:0]       ret_flags;
  logic             pending;
  logic             clear_pending;

  always_comb begin
    clear_pending = (state == VECTOR);
  end

  int_pending_latch u_pending (
    .clk       (Clk),
    .rst       (Rst),
    .int_level (Int),
    .clear     (clear_pending),
    .pending   (pending)
  );

  // Outputs are assigned alongside each transition so they describe the state being entered.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= IDLE;
      cnt         <= {CNT_W{1'b0}};
      ret_pc_lo   <= 16'h0000;
      ret_flags   <= 3'b000;
      stall_fetch <= 1'b0;
      inj_valid   <= 1'b0;
      inj_op      <= INJ_NONE;
      inj_data    <= 16'h0000;
      pc_load     <= 1'b0;
      pc_target   <= 32'h0000_0000;
      in_isr      <= 1'b0;
      int_ack     <= 1'b0;
    end else begin
      pc_load   <= 1'b0;
      pc_target <= 32'h0000_0000;
      int_ack   <= 1'b0;
      case (state)
        IDLE: begin
          if (pending && !in_isr) begin
            state       <= DRAIN;
            cnt         <= CNT_W'(DRAIN_CYC);
            stall_fetch <= 1'b1;
          end
        end
        DRAIN: begin
          if ((cnt == {CNT_W{1'b0}}) && !branch_busy) begin
            state     <= PUSH_H;
            ret_pc_lo <= fetch_pc[15:0];
            ret_flags <= flags;
            inj_valid <= 1'b1;
            inj_op    <= INJ_PUSH16;
            inj_data  <= fetch_pc[31:16];
          end else if (cnt != {CNT_W{1'b0}}) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            cnt <= cnt;
          end
        end
        PUSH_H: begin
          if (sp_ready) begin
            state    <= PUSH_L;
            inj_data <= ret_pc_lo;
          end
        end
        PUSH_L: begin
          if (sp_ready) begin
            state    <= PUSH_F;
            inj_data <= {13'b0, ret_flags};
          end
        end
        PUSH_F: begin
          if (sp_ready) begin
            state     <= VECTOR;
            inj_valid <= 1'b0;
            inj_op    <= INJ_NONE;
            inj_data  <= 16'h0000;
            pc_load   <= 1'b1;
            pc_target <= VEC_ADDR;
            int_ack   <= 1'b1;
          end
        end
        VECTOR: begin
          state       <= ISR;
          stall_fetch <= 1'b0;
          in_isr      <= 1'b1;
        end
        ISR: begin
          if (rti_retire) begin
            state  <= IDLE;
            in_isr <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          stall_fetch <= 1'b0;
          inj_valid   <= 1'b0;
          inj_op      <= INJ_NONE;
          inj_data    <= 16'h0000;
          in_isr      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_sequencer.sv
// Directed bench for int_sequencer: entry latency, drain extension, push
// back-pressure, re-entry after RTI and reset behaviour.
module tb_int_sequencer;
  import int_seq_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Int = 1'b0;
  logic        branch_busy = 1'b0;
  logic [31:0] fetch_pc = 32'h0001_2345;
  logic [2:0]  flags = 3'b101;
  logic        rti_retire = 1'b0;
  logic        sp_ready = 1'b1;
  logic        stall_fetch, inj_valid, pc_load, in_isr, int_ack;
  logic [1:0]  inj_op;
  logic [15:0] inj_data;
  logic [31:0] pc_target;

  int vectors = 0;
  int miscompares = 0;

  int_sequencer #(.DRAIN_CYC(4), .VEC_ADDR(32'h0000_0002)) dut (
    .Clk(Clk), .Rst(Rst), .Int(Int), .branch_busy(branch_busy),
    .fetch_pc(fetch_pc), .flags(flags), .rti_retire(rti_retire),
    .sp_ready(sp_ready), .stall_fetch(stall_fetch), .inj_valid(inj_valid),
    .inj_op(inj_op), .inj_data(inj_data), .pc_load(pc_load),
    .pc_target(pc_target), .in_isr(in_isr), .int_ack(int_ack)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_stall"}, 32'(stall_fetch), 32'd0);
    chk({tag, "_valid"}, 32'(inj_valid), 32'd0);
    chk({tag, "_op"}, 32'(inj_op), 32'd0);
    chk({tag, "_data"}, 32'(inj_data), 32'd0);
    chk({tag, "_pcload"}, 32'(pc_load), 32'd0);
    chk({tag, "_target"}, pc_target, 32'd0);
    chk({tag, "_isr"}, 32'(in_isr), 32'd0);
    chk({tag, "_ack"}, 32'(int_ack), 32'd0);
  endtask

  initial begin
    // reset state
    tick(); tick();
    chk_idle_outputs("rst");
    chk("rst_pending", 32'(dut.pending), 32'd0);
    Rst = 1'b0;
    tick();

    // single pulse with back-to-back pushes; edge sampled at e0
    Int = 1'b1;
    tick();
    chk("t1_pending", 32'(dut.pending), 32'd1);
    chk("t1_state_idle", 32'(dut.state), 32'(IDLE));
    Int = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk($sformatf("t1_stall_%0d", i), 32'(stall_fetch), (i <= 9) ? 32'd1 : 32'd0);
      chk($sformatf("t1_ack_%0d", i), 32'(int_ack), (i == 9) ? 32'd1 : 32'd0);
      chk($sformatf("t1_valid_%0d", i), 32'(inj_valid), (i >= 6 && i <= 8) ? 32'd1 : 32'd0);
      if (i == 6) chk("t1_push_h", 32'(inj_data), 32'h0001);
      if (i == 7) chk("t1_push_l", 32'(inj_data), 32'h2345);
      if (i == 8) chk("t1_push_f", 32'(inj_data), 32'h0005);
      if (i == 8) chk("t1_op", 32'(inj_op), 32'(INJ_PUSH16));
      if (i == 9) begin
        chk("t1_pcload", 32'(pc_load), 32'd1);
        chk("t1_target", pc_target, 32'h0000_0002);
        chk("t1_state_vec", 32'(dut.state), 32'(VECTOR));
        Int = 1'b1;  // edge lands on the clearing cycle
      end
      if (i == 10) begin
        chk("t1_isr", 32'(in_isr), 32'd1);
        chk("t1_target_zero", pc_target, 32'd0);
        chk("vec_edge_kept", 32'(dut.pending), 32'd1);
        Int = 1'b0;
      end
    end

    // kept edge re-enters after RTI; branch_busy extends DRAIN by 3 cycles
    rti_retire = 1'b1;
    tick();
    chk("t2_idle", 32'(dut.state), 32'(IDLE));
    chk("t2_pending", 32'(dut.pending), 32'd1);
    rti_retire = 1'b0;
    branch_busy = 1'b1;
    fetch_pc = 32'hABCD_1234;
    flags = 3'b010;
    tick();
    chk("t2_drain_entry", 32'(dut.state), 32'(DRAIN));
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk($sformatf("t2_drain_%0d", i), 32'(dut.state), 32'(DRAIN));
      chk($sformatf("t2_novalid_%0d", i), 32'(inj_valid), 32'd0);
    end
    branch_busy = 1'b0;
    fetch_pc = 32'h5555_6666;
    tick();
    chk("t2_push_h", 32'(inj_data), 32'h5555);
    chk("t2_state_ph", 32'(dut.state), 32'(PUSH_H));

    // sp_ready low two cycles during PUSH_L
    tick();
    chk("t3_push_l", 32'(inj_data), 32'h6666);
    sp_ready = 1'b0;
    tick();
    chk("t3_hold1", 32'(inj_data), 32'h6666);
    chk("t3_hold1_valid", 32'(inj_valid), 32'd1);
    tick();
    chk("t3_hold2", 32'(inj_data), 32'h6666);
    chk("t3_hold2_state", 32'(dut.state), 32'(PUSH_L));
    sp_ready = 1'b1;
    tick();
    chk("t3_push_f", 32'(inj_data), 32'h0002);
    tick();
    chk("t3_ack", 32'(int_ack), 32'd1);
    tick();
    chk("t3_isr", 32'(in_isr), 32'd1);

    // second edge during ISR: no stall until RTI retires
    Int = 1'b1;
    tick();
    chk("t4_pending", 32'(dut.pending), 32'd1);
    Int = 1'b0;
    tick();
    chk("t4_nostall", 32'(stall_fetch), 32'd0);
    chk("t4_state", 32'(dut.state), 32'(ISR));
    rti_retire = 1'b1;
    tick();
    chk("t4_idle", 32'(dut.state), 32'(IDLE));
    chk("t4_isr_off", 32'(in_isr), 32'd0);
    rti_retire = 1'b0;
    tick();
    chk("t4_drain", 32'(dut.state), 32'(DRAIN));
    chk("t4_stall", 32'(stall_fetch), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("t4_ack_%0d", i), 32'(int_ack), (i == 8) ? 32'd1 : 32'd0);
    end
    tick();

    // RTI and new edge on the same ISR cycle
    Int = 1'b1;
    rti_retire = 1'b1;
    tick();
    chk("t5_idle", 32'(dut.state), 32'(IDLE));
    chk("t5_pending", 32'(dut.pending), 32'd1);
    Int = 1'b0;
    rti_retire = 1'b0;
    tick();
    chk("t5_drain", 32'(dut.state), 32'(DRAIN));
    for (int i = 1; i <= 6; i++) tick();
    chk("t5_push_l", 32'(dut.state), 32'(PUSH_L));

    // reset mid-sequence, with Int held high across deassertion
    Rst = 1'b1;
    Int = 1'b1;
    tick();
    chk("t6_state", 32'(dut.state), 32'(IDLE));
    chk("t6_pending", 32'(dut.pending), 32'd0);
    chk_idle_outputs("t6");
    Rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("t6_nopend_%0d", i), 32'(dut.pending), 32'd0);
    end
    chk_idle_outputs("t6_post");

    // rti_retire outside ISR is ignored
    rti_retire = 1'b1;
    tick();
    chk("t7_rti_ignored", 32'(dut.state), 32'(IDLE));
    rti_retire = 1'b0;

    // fresh low-to-high edge triggers normally
    Int = 1'b0;
    tick();
    Int = 1'b1;
    tick();
    chk("t8_pending", 32'(dut.pending), 32'd1);
    tick();
    chk("t8_drain", 32'(dut.state), 32'(DRAIN));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/int_sequencer.md
# int_sequencer

Interrupt entry/exit sequencer for the 5-stage processor. It latches the external `Int` request and stalls fetch until the pipeline drains and no control-flow instruction is in flight. It then injects three stack pushes into the memory stage: return PC high, return PC low, then flags. Finally it redirects fetch to the interrupt vector and tracks the in-ISR state until RTI retires.

## Interface
Parameters:
- `DRAIN_CYC`, 4: cycles fetch stays stalled before injection (one per pipeline buffer).
- `VEC_ADDR`, 32'h0000_0002: PC loaded on interrupt entry.

Ports:
- `Clk`  in  1  clock. One clock domain, rising edge.
- `Rst`  in  1  synchronous, active-high reset.
- `Int`  in  1  external interrupt level, sampled every cycle.
- `branch_busy`  in  1  a JZ/JN/JC/JMP/CALL/RET/RTI is in ID, EX or MEM.
- `fetch_pc`  in  32  PC of the next instruction to fetch (return address).
- `flags`  in  3  CCR {C,N,Z}.
- `rti_retire`  in  1  RTI is in MEM this cycle.
- `sp_ready`  in  1  memory stage accepts the injected push this cycle.
- `stall_fetch`  out  1  hold PC and insert NOPs into IF/ID.
- `inj_valid`  out  1  injected memory op is valid.
- `inj_op`  out  2  00 NONE, 01 PUSH16, 10 reserved, 11 reserved.
- `inj_data`  out  16  push data.
- `pc_load`  out  1  one-cycle strobe: load `pc_target` into PC.
- `pc_target`  out  32  equals `VEC_ADDR` whenever `pc_load` is high, else 0.
- `in_isr`  out  1  the ISR is executing.
- `int_ack`  out  1  one-cycle pulse on vector load.

## Operation
- Edge detect: `int_prev` registers `Int`. A rising edge is `Int & ~int_prev` and sets `pending`. `int_prev` resets to 1, so an `Int` held high through reset does not fire.
- `pending` holds one request. Further edges while it is set collapse into it. It clears only in VECTOR.
- States:
  - IDLE: `pending & ~in_isr` → DRAIN. Load `cnt = DRAIN_CYC`.
  - DRAIN: `stall_fetch=1`. `cnt` decrements each cycle, saturating at 0. Exit when `cnt==0 & ~branch_busy`. On the exit cycle capture `ret_pc=fetch_pc` and `ret_flags=flags`, then go to PUSH_H.
  - PUSH_H: `inj_valid=1`, `inj_op=01`, `inj_data=ret_pc[31:16]`. Advance to PUSH_L on `sp_ready`, otherwise hold.
  - PUSH_L: as PUSH_H with `inj_data=ret_pc[15:0]`. Advance to PUSH_F on `sp_ready`.
  - PUSH_F: `inj_data={13'b0,ret_flags}`. Advance to VECTOR on `sp_ready`.
  - VECTOR: one cycle. `pc_load=1`, `pc_target=VEC_ADDR`, `int_ack=1`, `stall_fetch=1`, clear `pending`. Go to ISR.
  - ISR: `in_isr=1`, `stall_fetch=0`. On `rti_retire` go to IDLE. If `pending` is set, IDLE re-enters DRAIN on the next cycle.
- `stall_fetch` is 1 in DRAIN, PUSH_H, PUSH_L, PUSH_F and VECTOR, else 0.
- `inj_valid` is 1 only in the three PUSH states. Outside them `inj_op` and `inj_data` are 0.
- `rti_retire` outside ISR is ignored, since RTI with no interrupt is handled by the normal pipeline.

## Timing
- Reset: state IDLE, `pending=0`, `int_prev=1`, `cnt=0`, all outputs 0.
- Reset asserted mid-sequence aborts it. Any partial stack pushes are abandoned and the pipeline reset recovers.
- Latency with `sp_ready` constantly high and `branch_busy=0`, counting from the edge cycle t:
  - `pending` high at t+1, DRAIN at t+2;
  - PUSH_H at t+2+DRAIN_CYC+1;
  - VECTOR three cycles after that;
  - `int_ack` at t+DRAIN_CYC+6.
- `branch_busy` high when `cnt` reaches 0 extends DRAIN cycle by cycle. No capture happens until it drops.
- `sp_ready` low stretches the current PUSH state with outputs stable, and no push is skipped or duplicated.
- An edge arriving in the same cycle `pending` clears (VECTOR) is kept: `pending` stays 1 because set wins over clear.
- `rti_retire` and a new edge in the same ISR cycle: go to IDLE with `pending=1`.

## Structure
- Package `int_seq_pkg`: state encoding (3-bit enum IDLE, DRAIN, PUSH_H, PUSH_L, PUSH_F, VECTOR, ISR) and `inj_op` constants (INJ_NONE, INJ_PUSH16).
- Sub-module `int_pending_latch`: `int_prev` register, edge detect and the set/clear-priority pending flop.
- Everything else, including FSM and `cnt`, lives in `int_sequencer`.

## Test plan
- Single pulse, `fetch_pc=32'h0001_2345`, `flags=3'b101`, `sp_ready=1`: pushes 16'h0001, 16'h2345, 16'h0005 on consecutive cycles. Then `pc_load` with `pc_target=32'h0000_0002` and `int_ack` at cycle t+10 with `DRAIN_CYC=4`.
- `branch_busy` held high 3 cycles past `cnt==0`: `ret_pc` captured on the cycle it falls, and PUSH_H is delayed by exactly 3 cycles.
- `sp_ready` low for 2 cycles during PUSH_L: `inj_data` stays at the low half for 3 cycles, then PUSH_F follows.
- Second `Int` edge during ISR: no stall until `rti_retire`. DRAIN entered 1 cycle after IDLE, and a second `int_ack` follows.
- `Int` held high across `Rst` deassertion: no `pending`, all outputs 0. A subsequent low→high edge triggers normally.
- `Rst` asserted in PUSH_L: next cycle state is IDLE, `inj_valid=0`, `stall_fetch=0`, `pending=0`.
